button_event_ctrl: RTL
======================

# button_event_ctrl

Debounce controller for the board's push-button bank. It shares one debounce counter among NBTN raw button inputs, scanned round-robin. It keeps the debounced level of every button and reports each confirmed press or release as a one-entry event over a valid/ready handshake. It sits between the raw button pins and the game/display control logic, replacing one free-running counter per button.

## Interface
- NBTN, 4, number of buttons (2..2^IDW)
- IDW, 2, width of the event button index
- DB_LIMIT, 1048576, cycles a changed level must hold to be accepted (>= 2; 2^20 cycles at the board clock)
- CW, 21, debounce counter width; must hold DB_LIMIT-1
- clk  in  1  system clock, all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  NBTN  raw, asynchronous button levels (1 = pressed)
- evt_ready  in  1  consumer accepts the event
- btn_state  out  NBTN  debounced levels
- evt_valid  out  1  event pending
- evt_id  out  IDW  index of the button that changed
- evt_press  out  1  1 = press (0->1), 0 = release (1->0)
- busy  out  1  controller not in SCAN

## Operation
- Synchronizer: each btn_raw bit passes through 2 flops to give s[i]. Nothing else reads btn_raw.
- A button i is "pending" when s[i] != btn_state[i].
- State SCAN:
  - Search for a pending button starting at ptr and wrapping modulo NBTN. The first pending index found wins.
  - If one is found: cur <= index, cnt <= 0, go to COUNT. Otherwise stay in SCAN.
- State COUNT (only button cur is examined):
  - If s[cur] == btn_state[cur] (glitch or bounce reverted): cnt <= 0, ptr <= (cur+1) mod NBTN, go to SCAN. No event.
  - Else if cnt == DB_LIMIT-1 (commit):
    - btn_state[cur] <= s[cur]
    - evt_id <= cur, evt_press <= s[cur], evt_valid <= 1
    - go to EMIT
  - Else cnt <= cnt+1.
- State EMIT:
  - evt_valid, evt_id and evt_press hold steady.
  - When evt_ready is sampled high: evt_valid <= 0, ptr <= (cur+1) mod NBTN, go to SCAN.
  - Input changes in EMIT are not lost. Pending buttons are level-based and are found on a later scan.
- Buttons other than cur are ignored during COUNT and EMIT. Their mismatches persist and are serviced in round-robin order.
- busy = (state != SCAN).
- Counter arithmetic is unsigned CW-bit. cnt never exceeds DB_LIMIT-1, so it never wraps.

## Timing
- Reset values while rst is high or after rst rises, regardless of clk:
  - state = SCAN, ptr = 0, cur = 0, cnt = 0
  - sync flops = 0, btn_state = 0
  - evt_valid = 0, evt_id = 0, evt_press = 0, busy = 0
- Reset in the middle of COUNT or EMIT: the event is discarded and no partial btn_state update occurs. Inputs held high through reset produce a press event DB_LIMIT+2 cycles after rst falls.
- Latency: btn_raw changes and stays stable before edge k, with the controller in SCAN and no other button pending.
  - s changes at edge k+1.
  - SCAN detects at edge k+2.
  - Commit at edge k+DB_LIMIT+2, so evt_valid is high from that edge on.
- btn_state and evt_valid update on the same edge.
- Handshake:
  - The event transfers on a rising edge where evt_valid && evt_ready.
  - evt_valid drops the following cycle. The earliest next event is DB_LIMIT+1 cycles later.
  - evt_ready high in the commit cycle has no effect; acceptance happens only in EMIT.
- An unconsumed event blocks all further debouncing. At most one event is outstanding.
- Simultaneous pending buttons: service order is ptr, ptr+1, … mod NBTN. The last-serviced button gets lowest priority next.

## Test plan
- Single press (DB_LIMIT=4, evt_ready=1): btn_raw[2] 0->1 before edge 10 → evt_valid=1, evt_id=2, evt_press=1, btn_state=4'b0100 at edge 16; evt_valid=0 at edge 17.
- Glitch reject (DB_LIMIT=4): btn_raw[0] high for 3 cycles then low → no evt_valid, btn_state stays 0, busy returns to 0, ptr=1.
- Round-robin (DB_LIMIT=4, ptr=0): btn_raw[1] and btn_raw[3] rise together → event id=1, then id=3. No event is lost; btn_state=4'b1010.
- Backpressure: evt_ready=0 for 20 cycles after a commit → evt_valid, evt_id, evt_press stable throughout. A second button changed meanwhile is reported only after acceptance, DB_LIMIT+1 or more cycles later.
- Release: from btn_state[1]=1, btn_raw[1] falls → event id=1, evt_press=0, btn_state[1]=0.
- Async reset mid-COUNT: assert rst between clk edges → all outputs 0 immediately. No event appears for the aborted button, and it is re-debounced from scratch after rst falls.

Source files
------------

// File: rtl/button_event_ctrl.sv
// Debounce controller for a bank of push-buttons: one shared counter scans the
// buttons round-robin and reports each confirmed level change over valid/ready.
module button_event_ctrl #(
    parameter int NBTN     = 4,
    parameter int IDW      = 2,
    parameter int DB_LIMIT = 1048576,
    parameter int CW       = 21
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            evt_ready,
    output logic [NBTN-1:0] btn_state,
    output logic            evt_valid,
    output logic [IDW-1:0]  evt_id,
    output logic            evt_press,
    output logic            busy
);

    typedef enum logic [1:0] {SCAN, COUNT, EMIT} state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(DB_LIMIT - 1);

    state_t          state, state_nxt;
    logic [NBTN-1:0] sync1, s;
    logic [NBTN-1:0] pending;
    logic [NBTN-1:0] btn_state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [IDW-1:0]  cur, cur_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            evt_valid_nxt;
    logic [IDW-1:0]  evt_id_nxt;
    logic            evt_press_nxt;
    logic            found;
    logic [IDW-1:0]  found_idx;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return IDW'((int'(i) + 1) % NBTN);
    endfunction

    assign pending = s ^ btn_state;
    assign busy    = (state != SCAN);

    // First pending button at or after ptr, wrapping, wins.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int k = 0; k < NBTN; k++) begin
            if (!found && pending[(int'(ptr) + k) % NBTN]) begin
                found     = 1'b1;
                found_idx = IDW'((int'(ptr) + k) % NBTN);
            end
        end
    end

    // NOTE: every signal gets its hold value before the case statement, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cur_nxt       = cur;
        cnt_nxt       = cnt;
        btn_state_nxt = btn_state;
        evt_valid_nxt = evt_valid;
        evt_id_nxt    = evt_id;
        evt_press_nxt = evt_press;
        case (state)
            SCAN: begin
                if (found) begin
                    cur_nxt   = found_idx;
                    cnt_nxt   = '0;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (s[cur] == btn_state[cur]) begin
                    cnt_nxt   = '0;
                    ptr_nxt   = next_idx(cur);
                    state_nxt = SCAN;
                end else if (cnt == CNT_MAX) begin
                    btn_state_nxt[cur] = s[cur];
                    evt_id_nxt         = cur;
                    evt_press_nxt      = s[cur];
                    evt_valid_nxt      = 1'b1;
                    state_nxt          = EMIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            EMIT: begin
                // Acceptance is only possible here, never in the commit cycle.
                if (evt_ready) begin
                    evt_valid_nxt = 1'b0;
                    ptr_nxt       = next_idx(cur);
                    state_nxt     = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            s         <= '0;
            state     <= SCAN;
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
            btn_state <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_press <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            s         <= sync1;
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cur       <= cur_nxt;
            cnt       <= cnt_nxt;
            btn_state <= btn_state_nxt;
            evt_valid <= evt_valid_nxt;
            evt_id    <= evt_id_nxt;
            evt_press <= evt_press_nxt;
        end
    end

endmodule
